tmc4671_access_sequencer: RTL and testbench

Upstream command sequencer for the TMC4671 SPI master. It arbitrates host register accesses against a background poll of up to four motor-controller registers and drives the master's transmit/address/write/data inputs. It holds each frame's operands stable, consumes the master's `done` and read data, and enforces a minimum chip-select-high gap between frames.

---
 rtl/tmc4671_access_sequencer_if.sv | 39 +++
 rtl/tmc4671_access_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_tmc4671_access_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tmc4671_access_sequencer_if.sv
// ---------------------------------------------------------------------------
// tmc4671_access_sequencer_if
//
// Host-side command/response bus of the TMC4671 access sequencer.
//
// Signals:
//   cmd_valid  host request pending
//   cmd_ready  sequencer can accept a request (IDLE only)
//   cmd_write  1 = register write, 0 = register read
//   cmd_addr   7-bit TMC4671 register address
//   cmd_wdata  32-bit write data
//   rsp_valid  one-cycle pulse when a host access completes
//   rsp_rdata  read data, valid with rsp_valid for reads
//   rsp_err    high with rsp_valid when the access timed out
//
// Modports:
//   master  the host issuing register accesses
//   slave   the sequencer serving them
// ---------------------------------------------------------------------------
interface tmc4671_access_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [6:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/tmc4671_access_sequencer.sv
// ---------------------------------------------------------------------------
// tmc4671_access_sequencer
//
// Command sequencer in front of the TMC4671 SPI master. Host register
// accesses win over a background poll of up to four registers. Each frame's
// operands are held stable for the whole frame, and a fixed chip-select-high
// gap is inserted after every frame.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   host            command/response bus (slave modport)
//   poll_en         enables background polling
//   poll_data       slot k result in bits [32k+31:32k]
//   poll_update     one-cycle pulse per slot when its data refreshes
//   spi_transmit    one-cycle frame start pulse to the master
//   spi_address     register address to the master
//   spi_write       write/not-read to the master
//   spi_data_in     write data to the master
//   spi_data_out    read data from the master
//   spi_done        master end-of-frame pulse (only observed in WAIT)
//
// Optional feature (macro TMC4671_SEQ_TIMEOUT_EN): a WAIT-state watchdog that
// aborts a frame after TIMEOUT_CYCLES cycles without spi_done. Without the
// macro WAIT waits indefinitely and rsp_err is constant 0.
// ---------------------------------------------------------------------------
module tmc4671_access_sequencer #(
    parameter int         POLL_COUNT     = 2,
    parameter logic [6:0] POLL_ADDR0     = 7'h6B,
    parameter logic [6:0] POLL_ADDR1     = 7'h6A,
    parameter logic [6:0] POLL_ADDR2     = 7'h69,
    parameter logic [6:0] POLL_ADDR3     = 7'h00,
    parameter int         GAP_CYCLES     = 8,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic                         clk,
    input  logic                         reset,
    tmc4671_access_sequencer_if.slave    host,
    input  logic                         poll_en,
    output logic [127:0]                 poll_data,
    output logic [3:0]                   poll_update,
    output logic                         spi_transmit,
    output logic [6:0]                   spi_address,
    output logic                         spi_write,
    output logic [31:0]                  spi_data_in,
    input  logic [31:0]                  spi_data_out,
    input  logic                         spi_done
);

    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;
    typedef enum logic {OWNER_HOST, OWNER_POLL} owner_t;

    localparam bit         POLLING   = (POLL_COUNT > 0);
    localparam logic [1:0] LAST_SLOT = 2'((POLL_COUNT > 0) ? POLL_COUNT - 1 : 0);
    localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

    function automatic logic [6:0] poll_addr(input logic [1:0] s);
        case (s)
            2'd0:    return POLL_ADDR0;
            2'd1:    return POLL_ADDR1;
            2'd2:    return POLL_ADDR2;
            default: return POLL_ADDR3;
        endcase
    endfunction

    state_t      state;
    owner_t      owner;
    logic [1:0]  slot;
    logic [1:0]  next_slot;
    logic [6:0]  op_addr;
    logic        op_write;
    logic [31:0] op_wdata;
    logic [7:0]  gap_cnt;
    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;

    assign next_slot = (slot == LAST_SLOT) ? 2'd0 : slot + 2'd1;

    // The master samples these continuously during a frame, so they come
    // straight from operand registers that only load on IDLE -> START.
    assign spi_address = op_addr;
    assign spi_write   = op_write;
    assign spi_data_in = op_wdata;

    assign host.cmd_ready = cmd_ready_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_rdata = rsp_rdata_q;

`ifdef TMC4671_SEQ_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt;
    logic        rsp_err_q;
    assign host.rsp_err = rsp_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign host.rsp_err   = 1'b0;
`endif

    // NOTE: all state lives in this one clocked block and uses non-blocking
    // assignments, so every read sees the value from the previous edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            owner        <= OWNER_HOST;
            slot         <= 2'd0;
            op_addr      <= 7'd0;
            op_write     <= 1'b0;
            op_wdata     <= 32'd0;
            gap_cnt      <= 8'd0;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'd0;
            poll_data    <= 128'd0;
            poll_update  <= 4'd0;
            spi_transmit <= 1'b0;
`ifdef TMC4671_SEQ_TIMEOUT_EN
            to_cnt       <= 16'd0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low; the states below raise them for one cycle.
            rsp_valid_q  <= 1'b0;
            poll_update  <= 4'd0;
            spi_transmit <= 1'b0;
`ifdef TMC4671_SEQ_TIMEOUT_EN
            rsp_err_q    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // Host first; a poll only starts when no request is pending.
                    if (host.cmd_valid) begin
                        op_addr      <= host.cmd_addr;
                        op_write     <= host.cmd_write;
                        op_wdata     <= host.cmd_wdata;
                        owner        <= OWNER_HOST;
                        state        <= START;
                        cmd_ready_q  <= 1'b0;
                        spi_transmit <= 1'b1;
                    end else if (poll_en && POLLING) begin
                        op_addr      <= poll_addr(slot);
                        op_write     <= 1'b0;
                        op_wdata     <= 32'd0;
                        owner        <= OWNER_POLL;
                        state        <= START;
                        cmd_ready_q  <= 1'b0;
                        spi_transmit <= 1'b1;
                    end
                end
                START: begin
                    state <= WAIT;
`ifdef TMC4671_SEQ_TIMEOUT_EN
                    to_cnt <= 16'd0;
`endif
                end
                WAIT: begin
                    if (spi_done) begin
                        state   <= GAP;
                        gap_cnt <= GAP_LOAD;
                        if (owner == OWNER_HOST) begin
                            rsp_valid_q <= 1'b1;
                            if (!op_write) rsp_rdata_q <= spi_data_out;
                        end else begin
                            poll_data[{slot, 5'b0} +: 32] <= spi_data_out;
                            poll_update <= 4'b0001 << slot;
                            slot        <= next_slot;
                        end
                    end
`ifdef TMC4671_SEQ_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        // Abort: host sees an error response, a poll just moves on.
                        state   <= GAP;
                        gap_cnt <= GAP_LOAD;
                        if (owner == OWNER_HOST) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            slot <= next_slot;
                        end
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
`endif
                end
                GAP: begin
                    if (gap_cnt == 8'd0) begin
                        state       <= IDLE;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tmc4671_access_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tmc4671_access_sequencer
//
// Directed bench for tmc4671_access_sequencer (POLL_COUNT=2, GAP_CYCLES=8,
// TIMEOUT_CYCLES=64). A small SPI-master model answers frames with
// address-dependent data; expected host responses and poll updates are
// queued when stimulus is driven and popped by a monitor on the falling edge.
// The timeout step is built only with TMC4671_SEQ_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_tmc4671_access_sequencer;

    localparam int GAP = 8;
    localparam int TMO = 64;

    typedef struct {
        bit          is_host;
        logic [1:0]  slot;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         poll_en = 1'b0;
    logic [127:0] poll_data;
    logic [3:0]   poll_update;
    logic         spi_transmit;
    logic [6:0]   spi_address;
    logic         spi_write;
    logic [31:0]  spi_data_in;
    logic [31:0]  spi_data_out = 32'd0;
    logic         spi_done = 1'b0;

    tmc4671_access_sequencer_if bus();

    tmc4671_access_sequencer #(
        .POLL_COUNT(2),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .host(bus),
        .poll_en(poll_en),
        .poll_data(poll_data),
        .poll_update(poll_update),
        .spi_transmit(spi_transmit),
        .spi_address(spi_address),
        .spi_write(spi_write),
        .spi_data_in(spi_data_in),
        .spi_data_out(spi_data_out),
        .spi_done(spi_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] resp(input logic [6:0] a);
        return (a == 7'h00) ? 32'h0034_4671 : {16'hC0DE, 9'h0, a};
    endfunction

    // ---------------- SPI master model ----------------
    bit          busy = 0;
    bit          mute = 0;
    int          model_lat = 2;
    int          lat_cnt = 0;
    int          xmit_count = 0;
    int          xmit_cyc = 0;
    int          done_cyc = 0;
    logic [6:0]  cap_addr = '0;
    logic        cap_write = 1'b0;
    logic [31:0] cap_data = '0;
    logic [6:0]  addr_log[$];

    always @(negedge clk) begin
        spi_done = 1'b0;
        if (reset) begin
            busy = 0;
        end else if (busy) begin
            check("frame_operands_stable", {spi_address, spi_write, spi_data_in},
                  {cap_addr, cap_write, cap_data});
            check("transmit_low_in_frame", spi_transmit, 1'b0);
            if (lat_cnt == 0) begin
                spi_done     = 1'b1;
                spi_data_out = resp(cap_addr);
                busy         = 0;
                done_cyc     = cyc;
            end else begin
                lat_cnt--;
            end
        end else if (spi_transmit) begin
            xmit_count++;
            xmit_cyc  = cyc;
            cap_addr  = spi_address;
            cap_write = spi_write;
            cap_data  = spi_data_in;
            addr_log.push_back(spi_address);
            if (!mute) begin
                busy    = 1;
                lat_cnt = model_lat;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    exp_t exp_q[$];
    int   rsp_count = 0;
    int   poll_count = 0;
    int   rsp_cyc = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (bus.rsp_valid) begin
                rsp_count++;
                rsp_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_owner", 1'b1, e.is_host);
                    check("rsp_rdata", bus.rsp_rdata, e.rdata);
                    check("rsp_err", bus.rsp_err, e.err);
                end
            end
            if (poll_update != 4'd0) begin
                poll_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_poll_update", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("poll_owner", 1'b0, e.is_host);
                    check("poll_update", poll_update, 4'b0001 << e.slot);
                    check("poll_lane", poll_data[{e.slot, 5'b0} +: 32], e.rdata);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] last_rdata = 32'd0;
    int          ready_cyc = 0;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_poll(input logic [1:0] s, input logic [6:0] a);
        exp_t e;
        e.is_host = 0;
        e.slot    = s;
        e.rdata   = resp(a);
        e.err     = 1'b0;
        exp_q.push_back(e);
    endtask

    // Holds a request until accepted, then checks the one-cycle start pulse.
    task automatic host_req(input bit wr, input logic [6:0] a, input logic [31:0] d,
                            output int acc, output int prev_done);
        int b = 0;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && b < 500) begin
            tick();
            b++;
        end
        check("accept_within_budget", b < 500, 1'b1);
        acc       = cyc;
        prev_done = done_cyc;
        tick();
        bus.cmd_valid = 1'b0;
        check("transmit_at_accept+1", spi_transmit, 1'b1);
        tick();
        check("transmit_single_cycle", spi_transmit, 1'b0);
    endtask

    task automatic wait_rsp(input int n0);
        int b = 0;
        while (rsp_count <= n0 && b < 500) begin
            tick();
            b++;
        end
        check("rsp_arrived", rsp_count > n0, 1'b1);
    endtask

    task automatic wait_ready();
        int b = 0;
        while (!bus.cmd_ready && b < 1000) begin
            tick();
            b++;
        end
        check("ready_within_budget", bus.cmd_ready, 1'b1);
        ready_cyc = cyc;
    endtask

    task automatic wait_polls(input int target);
        int b = 0;
        while (poll_count < target && b < 1000) begin
            tick();
            b++;
        end
        check("polls_arrived", poll_count >= target, 1'b1);
    endtask

    task automatic do_host(input bit wr, input logic [6:0] a, input logic [31:0] d,
                           input bit after_poll);
        exp_t e;
        int   n0, x0, acc, pd;
        e.is_host  = 1;
        e.slot     = 2'd0;
        e.err      = 1'b0;
        e.rdata    = wr ? last_rdata : resp(a);
        last_rdata = e.rdata;
        exp_q.push_back(e);
        n0 = rsp_count;
        x0 = xmit_count;
        host_req(wr, a, d, acc, pd);
        if (after_poll) check("host_after_poll_gap", acc, pd + 1 + GAP);
        wait_rsp(n0);
        check("one_transmit", xmit_count - x0, 1);
        check("transmit_cycle", xmit_cyc, acc + 1);
        check("host_operands", {cap_addr, cap_write, cap_data}, {a, wr, d});
        check("rsp_at_done+1", rsp_cyc, done_cyc + 1);
        wait_ready();
        check("ready_after_gap", ready_cyc, done_cyc + 1 + GAP);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n0, x0, acc, pd, b;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 7'd0;
        bus.cmd_wdata = 32'd0;

        // Reset state
        repeat (3) tick();
        check("reset_cmd_ready", bus.cmd_ready, 1'b1);
        check("reset_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 34'd0);
        check("reset_poll", {poll_update, poll_data}, 132'd0);
        check("reset_spi", {spi_transmit, spi_address, spi_write, spi_data_in}, 41'd0);
        reset = 1'b0;
        repeat (100) tick();
        check("idle_no_transmit", xmit_count, 0);
        check("idle_cmd_ready", bus.cmd_ready, 1'b1);

        // Host write then host read
        do_host(1'b1, 7'h1C, 32'h0001_0001, 1'b0);
        do_host(1'b0, 7'h00, 32'hDEAD_0000, 1'b0);

        // Background polling alternates 6B, 6A, 6B
        addr_log.delete();
        push_poll(2'd0, 7'h6B);
        push_poll(2'd1, 7'h6A);
        push_poll(2'd0, 7'h6B);
        n0 = poll_count;
        poll_en = 1'b1;
        wait_polls(n0 + 3);
        poll_en = 1'b0;
        check("poll_log_size", addr_log.size(), 3);
        if (addr_log.size() >= 3)
            check("poll_addr_seq", {addr_log[0], addr_log[1], addr_log[2]},
                  {7'h6B, 7'h6A, 7'h6B});
        check("poll_write_low", cap_write, 1'b0);
        check("poll_data_lanes", poll_data, {64'd0, resp(7'h6A), resp(7'h6B)});
        wait_ready();
        x0 = xmit_count;
        repeat (20) tick();
        check("poll_stops_when_disabled", xmit_count, x0);

        // Host request raised during a poll frame
        addr_log.delete();
        push_poll(2'd1, 7'h6A);
        poll_en = 1'b1;
        b = 0;
        while (!busy && b < 200) begin
            tick();
            b++;
        end
        check("poll_frame_started", busy, 1'b1);
        do_host(1'b0, 7'h10, 32'h1234_5678, 1'b1);
        push_poll(2'd0, 7'h6B);
        wait_polls(poll_count + 1);
        poll_en = 1'b0;
        check("mixed_log_size", addr_log.size(), 3);
        if (addr_log.size() >= 3)
            check("mixed_addr_seq", {addr_log[0], addr_log[1], addr_log[2]},
                  {7'h6A, 7'h10, 7'h6B});
        wait_ready();

        // Reset in the middle of a frame
        model_lat = 20;
        n0 = rsp_count;
        host_req(1'b0, 7'h05, 32'd0, acc, pd);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("midreset_ready", bus.cmd_ready, 1'b1);
        check("midreset_outputs", {spi_transmit, spi_address, bus.rsp_valid, bus.rsp_rdata},
              41'd0);
        check("midreset_poll_data", poll_data, 128'd0);
        reset = 1'b0;
        last_rdata = 32'd0;
        model_lat = 2;
        x0 = xmit_count;
        repeat (40) tick();
        check("midreset_no_rsp", rsp_count, n0);
        check("midreset_no_transmit", xmit_count, x0);

`ifdef TMC4671_SEQ_TIMEOUT_EN
        // Master never answers: error response after the watchdog expires
        begin
            exp_t e;
            e.is_host = 1;
            e.slot    = 2'd0;
            e.err     = 1'b1;
            e.rdata   = last_rdata;
            exp_q.push_back(e);
        end
        mute = 1;
        n0 = rsp_count;
        host_req(1'b0, 7'h03, 32'd0, acc, pd);
        wait_rsp(n0);
        check("timeout_rsp_cycle", rsp_cyc, xmit_cyc + 1 + TMO);
        wait_ready();
        check("timeout_ready_after_gap", ready_cyc, rsp_cyc + GAP);
        mute = 0;
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
